// File: rtl/activation_scheduler.sv
// Streams one layer of accumulated neuron values from the result buffer through
// pass / ReLU / leaky-ReLU, with credit-limited reads feeding a 2-entry output FIFO.
module activation_scheduler #(
   parameter int FRACTION_WIDTH = 15,
   parameter int BIT_WIDTH      = 32,
   parameter int ADDR_WIDTH     = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   count,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [BIT_WIDTH-1:0]  rd_data,
   output logic                  out_valid,
   output logic [BIT_WIDTH-1:0]  out_data,
   output logic [ADDR_WIDTH-1:0] out_index,
   input  logic                  out_ready
);

   if (FRACTION_WIDTH >= BIT_WIDTH) begin : g_bad_fraction
      $error("FRACTION_WIDTH must be smaller than BIT_WIDTH");
   end

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t                state_q, state_d;
   logic [1:0]            mode_q, mode_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [ADDR_WIDTH:0]   issued_q, issued_d;
   logic [ADDR_WIDTH-1:0] wr_idx_q, wr_idx_d;
   logic                  inflight_q;
   logic                  done_q, done_d;
   logic [1:0]            occ_q, occ_d;
   logic [BIT_WIDTH-1:0]  head_data_q, head_data_d, skid_data_q, skid_data_d;
   logic [ADDR_WIDTH-1:0] head_idx_q, head_idx_d, skid_idx_q, skid_idx_d;

   logic                  push, pop, last_hs;
   logic [2:0]            credit;
   logic [BIT_WIDTH-1:0]  act;

   function automatic logic [BIT_WIDTH-1:0] activate(input logic [BIT_WIDTH-1:0] x,
                                                     input logic [1:0] m);
      logic [BIT_WIDTH-2:0] mag;
      mag = x[BIT_WIDTH-2:0] >> 3;
      case (m)
         2'd1:    activate = x[BIT_WIDTH-1] ? '0 : x;
         2'd2:    activate = x[BIT_WIDTH-1] ? {1'b1, mag} : x;
         default: activate = x;
      endcase
   endfunction

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign out_valid = (occ_q != 2'd0);
   assign out_data  = head_data_q;
   assign out_index = head_idx_q;
   assign rd_addr   = base_q + issued_q[ADDR_WIDTH-1:0];

   assign pop     = out_valid && out_ready;
   assign push    = inflight_q;
   assign act     = activate(rd_data, mode_q);
   assign last_hs = pop && ({1'b0, head_idx_q} == (count_q - 1'b1));

   // A new read is allowed only if the FIFO can still hold it once every
   // outstanding read has landed, so the FIFO can never overflow.
   assign credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign rd_en  = (state_q == RUN) && (issued_q < count_q) && (credit < 3'd2);

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      base_d   = base_q;
      count_d  = count_q;
      issued_d = issued_q;
      wr_idx_d = wr_idx_q;
      done_d   = 1'b0;
      if (push) wr_idx_d = wr_idx_q + 1'b1;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d  = RUN;
                  mode_d   = mode;
                  base_d   = base_addr;
                  count_d  = count;
                  issued_d = '0;
                  wr_idx_d = '0;
               end
            end
         end
         RUN: begin
            if (rd_en) begin
               issued_d = issued_q + 1'b1;
               if ((issued_q + 1'b1) == count_q) state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (last_hs) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      occ_d       = occ_q;
      head_data_d = head_data_q;
      head_idx_d  = head_idx_q;
      skid_data_d = skid_data_q;
      skid_idx_d  = skid_idx_q;
      case ({push, pop})
         2'b10: begin
            if (occ_q == 2'd0) begin
               head_data_d = act;
               head_idx_d  = wr_idx_q;
            end else begin
               skid_data_d = act;
               skid_idx_d  = wr_idx_q;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            if (occ_q == 2'd2) begin
               head_data_d = skid_data_q;
               head_idx_d  = skid_idx_q;
            end
            occ_d = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               head_data_d = act;
               head_idx_d  = wr_idx_q;
            end else begin
               head_data_d = skid_data_q;
               head_idx_d  = skid_idx_q;
               skid_data_d = act;
               skid_idx_d  = wr_idx_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mode_q      <= '0;
         base_q      <= '0;
         count_q     <= '0;
         issued_q    <= '0;
         wr_idx_q    <= '0;
         inflight_q  <= 1'b0;
         done_q      <= 1'b0;
         occ_q       <= '0;
         head_data_q <= '0;
         head_idx_q  <= '0;
         skid_data_q <= '0;
         skid_idx_q  <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         base_q      <= base_d;
         count_q     <= count_d;
         issued_q    <= issued_d;
         wr_idx_q    <= wr_idx_d;
         inflight_q  <= rd_en;
         done_q      <= done_d;
         occ_q       <= occ_d;
         head_data_q <= head_data_d;
         head_idx_q  <= head_idx_d;
         skid_data_q <= skid_data_d;
         skid_idx_q  <= skid_idx_d;
      end
   end

endmodule

// File: doc/activation_scheduler.md
# activation_scheduler

Sequences one layer's worth of accumulated neuron values through the activation function. On a start command it reads `count` words from the layer result buffer starting at `base_addr`, and applies the selected activation (pass-through, ReLU or leaky ReLU). Results are streamed to the next stage over a valid/ready interface. It sits between the MAC result buffer and the next-layer input writer and owns all read scheduling of that buffer during the activation pass.

## Interface
- FRACTION_WIDTH, 15, fractional bits of the fixed-point word (carried only; no arithmetic depends on it)
- BIT_WIDTH, 32, data word width; MSB is the sign bit
- ADDR_WIDTH, 10, result buffer address width
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle command strobe; ignored while busy
- mode  in  2  0 = pass, 1 = ReLU, 2 = leaky ReLU, 3 = pass
- base_addr  in  ADDR_WIDTH  first buffer address
- count  in  ADDR_WIDTH+1  element count, 0..2^ADDR_WIDTH
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the pass is complete
- rd_en  out  1  buffer read request
- rd_addr  out  ADDR_WIDTH  buffer read address
- rd_data  in  BIT_WIDTH  buffer data, valid exactly one cycle after rd_en
- out_valid  out  1  output word valid
- out_data  out  BIT_WIDTH  activated word
- out_index  out  ADDR_WIDTH  element index 0..count-1 of out_data, relative to base
- out_ready  in  1  downstream accepts when high with out_valid

## Operation
- FSM states are IDLE, RUN and FLUSH.
  - IDLE→RUN on start with count≠0. `mode`, `base_addr` and `count` are latched at that edge.
  - IDLE stays in IDLE on start with count=0, and done pulses the following cycle. No reads are issued.
  - RUN→FLUSH when the last read is issued (issued == count).
  - FLUSH→IDLE on the handshake of the element with index count-1. done pulses in the next cycle, and busy falls in the same cycle.
- Reads:
  - rd_addr = base + issued, modulo 2^ADDR_WIDTH (wraps).
  - rd_en = RUN && issued<count && (occ + inflight − pop) < 2.
  - occ is the output buffer occupancy (0..2). inflight is the rd_en of the previous cycle. pop = out_valid && out_ready.
- Output buffer:
  - 2-entry FIFO (output register plus skid slot). rd_data is activated combinationally and written into the FIFO in its valid cycle.
  - Order is preserved. The FIFO never overflows, because the credit rule above prevents it.
- Activation, with x = rd_data:
  - pass: x.
  - ReLU: x[MSB]=1 → 0, else x.
  - leaky ReLU: x[MSB]=1 → {1'b1, x[BIT_WIDTH-2:0] >> 3} (sign kept, the other bits logically shifted right by 3, zero-filled), else x.
- out_data and out_index are held stable while out_valid && !out_ready.
- start while busy is ignored and has no effect on the latched parameters.
- Reset, including mid-pass:
  - All outputs return to 0: busy, done, rd_en, rd_addr, out_valid, out_data, out_index.
  - FSM returns to IDLE, counters clear, and the FIFO empties. An in-flight read is discarded.

## Timing
- Start accepted at edge E0: busy and rd_en high after E0 (rd_addr = base).
- rd_data arrives after E1 and is captured at E2; out_valid is high after E2. First-output latency is 2 cycles from the first read.
- Throughput is 1 element per cycle sustained while out_ready=1.
- With out_ready=0, at most 2 elements are read ahead, and rd_en stays low until a pop.
- done is high for exactly one cycle. A new start is accepted in the done cycle.

## Test plan
- Pass mode, base=0, count=4, buffer {5, −3, 0x7FFFFFFF, 0}, out_ready=1.
  - Required: outputs identical in order with out_index 0..3; 4 consecutive valid cycles; done exactly 1 cycle after the 4th handshake.
- ReLU, count=3, data {0x00010000, 0x80000008, 0xFFFFFFFF}.
  - Required: outputs {0x00010000, 0, 0}.
- Leaky ReLU, data {0x80000040, 0x00000040}.
  - Required: outputs {0x80000008, 0x00000040}.
- Backpressure: out_ready low for 5 cycles mid-stream.
  - Required: no more than 2 reads ahead of the last handshake; out_data and out_index stable while stalled; no loss or duplication across count=8.
- Wrap and zero length:
  - base=1022, count=4 with ADDR_WIDTH=10. Required: rd_addr sequence 1022, 1023, 0, 1.
  - count=0. Required: done the next cycle, no rd_en, busy stays 0.
- Reset and ignored start:
  - Assert rst_n low mid-pass. Required: all outputs 0 immediately; after release, a new start runs cleanly from index 0.
  - Issue start while busy. Required: ignored.
